fp_addsub_arbiter: RTL
======================

# fp_addsub_arbiter

- Shares one single-precision (IEEE-754 binary32) `adder_subtracter` datapath among `NREQ` requesters.
- Uses round-robin arbitration, valid/ready handshakes on both request and response sides, and registered operands and result.
- Sits between the processor's FP issue ports (e.g. FPU pipe, address/conversion helpers) and the shared combinational adder.
- Also sequences each operation and keeps a wrap-around count of completed operations.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of `resp_id`, equal to ceil(log2(NREQ)).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NREQ: per-requester request valid.
- `req_ready`, out, NREQ: per-requester grant/accept; at most one bit set.
- `req_op`, in, NREQ: per requester; 0 = add, 1 = subtract (a − b).
- `req_a`, in, 32*NREQ: operand A, requester i at bits [32i+31:32i].
- `req_b`, in, 32*NREQ: operand B, same packing as `req_a`.
- `resp_valid`, out, 1: result available.
- `resp_ready`, in, 1: consumer accepts result.
- `resp_data`, out, 32: binary32 result.
- `resp_id`, out, IDW: index of the requester that owns the result.
- `resp_flags`, out, 3: {inf_or_nan_operand, result_inf, result_zero}; see Configuration.
- `busy`, out, 1: high in any state other than IDLE.
- `op_count`, out, 16: number of completed responses; wraps at 16 bits.

## Operation

The controller is a three-state FSM: IDLE → EXEC → DONE → IDLE.

- **IDLE**
  - Winner is the first set `req_valid[i]` searching from `ptr+1` upward, mod NREQ. `ptr` is the last granted index.
  - `req_ready[winner]` = 1, driven combinationally from `req_valid`. All other `req_ready` bits are 0.
  - On the accept edge:
    - Latch `req_a[winner]` into `opa`.
    - Latch `req_b[winner]` into `opb`, with bit 31 inverted when `req_op[winner]` = 1.
    - Latch the winner index into `id_r` and set `ptr` = winner.
    - Go to EXEC.
  - With no valid request, stay in IDLE; `ptr` is unchanged.
- **EXEC**
  - `opa` and `opb` drive the combinational datapath.
  - Capture its output into `res_r` and the flags into `flags_r`.
  - Go to DONE.
  - `req_ready` is all 0.
- **DONE**
  - `resp_valid` = 1; `resp_data`, `resp_id` and `resp_flags` come from registers and are stable.
  - When `resp_valid && resp_ready`: `op_count` += 1 (16'hFFFF wraps to 0), then go to IDLE.
  - Otherwise hold DONE indefinitely (backpressure).
- **Requester rules**
  - A requester holds `req_valid`, `req_op`, `req_a` and `req_b` stable until it sees `req_ready` high.
  - Dropping `req_valid` before the grant is legal; the request is simply not served.
- **Fairness**: a requester that stays valid is served within NREQ grants.
- **Subtraction**: performed only by the sign flip of B. The datapath always adds.

## Timing

- Reset values:
  - `req_ready` = 0, `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `resp_flags` = 0, `busy` = 0, `op_count` = 0.
  - State = IDLE; `ptr` = NREQ−1, so requester 0 has first priority.
- Latency:
  - Accept at edge T.
  - Result captured at T+1.
  - `resp_valid` high during the cycle after edge T+1, i.e. 2 cycles after accept.
- Throughput: at most one operation per 3 cycles when `resp_ready` is held at 1. No new grant is issued in the cycle that `resp_valid` is accepted; IDLE follows.
- A simultaneous change of `req_valid` bits in IDLE is resolved purely by the rotating priority. There is no tie state.
- Reset asserted mid-operation (EXEC or DONE): the in-flight result is discarded, with no response and no count. All registers take their reset values on that edge.
- `busy` is registered-state decoded: 1 in EXEC and DONE.

## Configuration

Macro `FP_ADDSUB_ARB_FLAGS_EN`.

- **Defined**: `flags_r` is captured in EXEC.
  - bit2 = either operand has exponent 8'hFF.
  - bit1 = result exponent 8'hFF.
  - bit0 = result bits [30:0] == 0.
- **Undefined**: the flag logic and registers are not built, and `resp_flags` is tied to 3'b000.
- Everything else is identical in both builds.

## Test plan

- Reset, then single request from requester 2: a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0 → `req_ready[2]` high in the request cycle; `resp_valid` 2 cycles later with `resp_data`=0x40400000, `resp_id`=2, `op_count`=1 after the handshake.
- Subtract, requester 0: a=0x40400000, b=0x3F800000, op=1 → `resp_data`=0x40000000.
- All 4 requesters valid continuously, `resp_ready`=1 → grant order 0,1,2,3,0; one response every 3 cycles.
- Hold `resp_ready`=0 for 10 cycles in DONE → `resp_valid` and `resp_data` stable throughout, all `req_ready` bits 0, `op_count` unchanged.
- Assert `rst` in the EXEC cycle → next cycle `busy`=0, `resp_valid`=0, `op_count`=0, and the next grant goes to requester 0.
- With `FP_ADDSUB_ARB_FLAGS_EN`: a=0x7F800000 (+inf), b=0x3F800000 → `resp_data`=0x7F800000, `resp_flags`=3'b110. Without the macro, the same stimulus gives `resp_flags`=3'b000.

Source files
------------

// File: rtl/fp_addsub_arbiter_if.sv
// Request/response bundle between FP issue ports and the shared add/sub unit.
// master = requesters + result consumer, slave = fp_addsub_arbiter.
interface fp_addsub_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_data;
  logic [IDW-1:0]     resp_id;
  logic [2:0]         resp_flags;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_flags
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_flags
  );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one binary32 adder among NREQ requesters.
// Define FP_ADDSUB_ARB_FLAGS_EN to build the resp_flags capture logic.
module fp_addsub_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  fp_addsub_arbiter_if.slave        bus,
  output logic                      busy,
  output logic [15:0]               op_count
);
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, id_r, win;
  logic           win_vld;
  int unsigned    arb_idx;
  logic [31:0]    opa, opb, res_r, sum_w;

  // Rotating priority: search starts just above the last granted index.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    arb_idx = 0;
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      arb_idx = (32'(ptr) + k) % NREQ_U;
      if (!win_vld && bus.req_valid[arb_idx]) begin
        win_vld = 1'b1;
        win     = IDW'(arb_idx);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    case (state)
      IDLE: if (win_vld) begin
        bus.req_ready[win] = 1'b1;
        state_nxt          = EXEC;
      end
      EXEC:    state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IDW'(NREQ - 1);
      id_r     <= '0;
      opa      <= '0;
      opb      <= '0;
      res_r    <= '0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (win_vld) begin
          opa  <= bus.req_a[32*win +: 32];
          opb  <= bus.req_b[32*win +: 32] ^ {bus.req_op[win], 31'd0};
          id_r <= win;
          ptr  <= win;
        end
        EXEC:    res_r <= sum_w;
        DONE:    if (bus.resp_ready) op_count <= op_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_data  = res_r;
  assign bus.resp_id    = id_r;

  // Combinational binary32 adder, round-to-nearest-even, subnormal aware.
  logic        x_big_a, x_sl, x_sub;
  logic [23:0] x_ma, x_mb, x_ml, x_ms;
  logic [7:0]  x_ea, x_eb, x_el, x_es, x_d;
  logic [26:0] x_al, x_as, x_mask, x_nm;
  logic [27:0] x_sum;
  logic [9:0]  x_e, x_sh;
  logic [4:0]  x_lz;
  logic        x_up;
  logic [24:0] x_mr;

  always_comb begin
    x_ea    = (opa[30:23] == 8'd0) ? 8'd1 : opa[30:23];
    x_eb    = (opb[30:23] == 8'd0) ? 8'd1 : opb[30:23];
    x_ma    = {opa[30:23] != 8'd0, opa[22:0]};
    x_mb    = {opb[30:23] != 8'd0, opb[22:0]};
    x_big_a = (opa[30:0] >= opb[30:0]);
    x_sl    = x_big_a ? opa[31] : opb[31];
    x_ml    = x_big_a ? x_ma : x_mb;
    x_ms    = x_big_a ? x_mb : x_ma;
    x_el    = x_big_a ? x_ea : x_eb;
    x_es    = x_big_a ? x_eb : x_ea;
    x_d     = x_el - x_es;
    x_sub   = opa[31] ^ opb[31];
    x_al    = {x_ml, 3'b000};
    x_mask  = (27'd1 << x_d[4:0]) - 27'd1;
    if (x_d >= 8'd27) x_as = {26'd0, |x_ms};
    else x_as = ({x_ms, 3'b000} >> x_d[4:0]) | {26'd0, |({x_ms, 3'b000} & x_mask)};
    x_sum = x_sub ? ({1'b0, x_al} - {1'b0, x_as}) : ({1'b0, x_al} + {1'b0, x_as});

    x_lz = 5'd27;
    for (int unsigned i = 0; i < 27; i++) if (x_sum[i]) x_lz = 5'(26 - i);

    // Left normalisation stops at exponent 1 so tiny results come out subnormal.
    x_e  = {2'b00, x_el};
    x_sh = '0;
    if (x_sum[27]) begin
      x_nm = {x_sum[27:2], |x_sum[1:0]};
      x_e  = x_e + 10'd1;
    end else begin
      x_sh = ({5'd0, x_lz} < (x_e - 10'd1)) ? {5'd0, x_lz} : (x_e - 10'd1);
      x_nm = x_sum[26:0] << x_sh;
      x_e  = x_e - x_sh;
      if (!x_nm[26]) x_e = '0;
    end

    x_up = x_nm[2] & (x_nm[1] | x_nm[0] | x_nm[3]);
    x_mr = {1'b0, x_nm[26:3]} + {24'd0, x_up};
    if (x_mr[24]) begin
      x_mr = x_mr >> 1;
      x_e  = x_e + 10'd1;
    end else if (x_e == 10'd0 && x_mr[23]) begin
      x_e = 10'd1;
    end

    if (x_e >= 10'd255) sum_w = {x_sl, 8'hFF, 23'd0};
    else                sum_w = {x_sl, x_e[7:0], x_mr[22:0]};
    if (x_sum == '0) sum_w = {opa[31] & opb[31], 31'd0};

    if (opa[30:23] == 8'hFF || opb[30:23] == 8'hFF) begin
      if ((opa[30:23] == 8'hFF && opa[22:0] != 23'd0) ||
          (opb[30:23] == 8'hFF && opb[22:0] != 23'd0) ||
          (opa[30:23] == 8'hFF && opb[30:23] == 8'hFF && x_sub))
        sum_w = 32'h7FC0_0000;
      else if (opa[30:23] == 8'hFF)
        sum_w = opa;
      else
        sum_w = opb;
    end
  end

`ifdef FP_ADDSUB_ARB_FLAGS_EN
  logic [2:0] flags_r;

  always_ff @(posedge clk) begin
    if (rst) flags_r <= '0;
    else if (state == EXEC)
      flags_r <= {(opa[30:23] == 8'hFF) || (opb[30:23] == 8'hFF),
                  sum_w[30:23] == 8'hFF,
                  sum_w[30:0] == 31'd0};
  end

  assign bus.resp_flags = flags_r;
`else
  assign bus.resp_flags = 3'b000;
`endif
endmodule
